discrete_weighted_mixer: RTL and testbench
==========================================

# discrete_weighted_mixer

Sums NUM_INPUTS signed 16-bit discrete voice outputs with per-input fixed-point gains into one signed 16-bit sample. It uses one time-multiplexed multiply-accumulate, scheduled once per audio sample period. It sits directly upstream of the RC high-pass (coupling-capacitor) stage, which consumes `out` on the same `audio_clk_en` strobe.

## Interface
Parameters:
- CLOCK_RATE, 50000000, system clock in Hz.
- SAMPLE_RATE, 48000, audio sample rate in Hz.
- NUM_INPUTS, 4, number of mixed inputs. Legal range 2..8.
- GAINS_12_SHIFTED, {4{16'd4096}}, packed NUM_INPUTS×16-bit vector of unsigned Q4.12 gains. Entry i occupies bits [16i+15:16i]. 4096 = unity gain.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- audio_clk_en, input, 1, one-cycle sample strobe at SAMPLE_RATE.
- in, input, NUM_INPUTS×16, packed signed samples. Input i occupies bits [16i+15:16i].
- out, output, 16 signed, mixed sample. Holds its value between updates.
- out_valid, output, 1, one-cycle pulse when `out` updates.
- busy, output, 1, high while a mix is in progress.
- clip, output, 1, saturation flag for the current `out` value.
- overrun, output, 1, sticky flag: an `audio_clk_en` arrived while busy. Cleared only by reset.

## Operation
- States: IDLE, ACCUM, SCALE.
- IDLE, on `audio_clk_en`:
  - snapshot all inputs into registers;
  - acc ← 0, idx ← 0;
  - go to ACCUM.
- ACCUM, each cycle:
  - acc ← acc + snapshot[idx] × gain[idx], signed × unsigned;
  - idx ← idx+1;
  - after idx = NUM_INPUTS−1, go to SCALE.
- SCALE:
  - r = (acc + 2048) >>> 12, arithmetic (round half toward +∞);
  - saturate r to [−32768, 32767];
  - out ← saturated r, clip ← (r was out of range), out_valid ← 1;
  - go to IDLE.
- Arithmetic widths:
  - each product is 33 bits signed;
  - acc is 36 bits signed, so no overflow is possible for NUM_INPUTS ≤ 8 at maximum gain 65535.
- `audio_clk_en` in ACCUM or SCALE:
  - the request is dropped and overrun ← 1;
  - the mix in flight is unaffected.
- `in` may change at any time after the snapshot cycle without affecting the current mix.
- Elaboration-time check: CLOCK_RATE/SAMPLE_RATE ≥ NUM_INPUTS+3; otherwise $error.
- Reset values: out = 0, out_valid = 0, busy = 0, clip = 0, overrun = 0. State = IDLE, acc = 0, idx = 0, snapshots = 0.
- Reset mid-operation: aborts the mix immediately. No out_valid is issued and `out` returns to 0.
- Reset and `audio_clk_en` in the same cycle: reset wins and the strobe is ignored.

## Timing
- Cycle 0: `audio_clk_en` sampled in IDLE.
- Cycles 1..NUM_INPUTS: ACCUM, one product per cycle.
- Cycle NUM_INPUTS+1: SCALE.
- Cycle NUM_INPUTS+2: out, clip and out_valid are visible. Total latency is NUM_INPUTS+2 clocks, i.e. 6 for the defaults.
- busy is high during cycles 1..NUM_INPUTS+1.
- The first cycle back in IDLE, cycle NUM_INPUTS+2, accepts a new strobe.
- out_valid is high for exactly one cycle per accepted strobe.
- clip holds until the next out_valid.
- The downstream filter samples `out` at its next `audio_clk_en`, giving a one-sample pipeline delay. This is intended.

## Structure
- Shared package discrete_audio_pkg:
  - typedef sample_t (logic signed [15:0]);
  - GAIN_UNITY_12 = 4096;
  - function sat16(input logic signed [35:0]) returning sample_t plus a clip bit.
  - Other discrete stages reuse all three.
- State enum mixer_state_t is local to the module.
- One sub-module is natural: sample_saturator. It takes a 36-bit accumulator and produces the rounded, saturated 16-bit value and the clip bit, combinationally. It is instantiated in the SCALE path.

## Test plan
Defaults apply: NUM_INPUTS = 4, unity gains, unless stated.
- **Basic sum:** in = {0, −500, 2000, 1000}, strobe at cycle 0 → out = 2500, clip = 0, out_valid pulse at cycle 6, busy high during cycles 1–5.
- **Saturation:** gains all 8192, every input 20000 → out = 32767, clip = 1. Every input −32768 at unity → out = −32768, clip = 1.
- **Rounding:** gain[0] = 2048, others 0.
  - in[0] = 3 → out = 2.
  - in[0] = −3 → out = −1.
  - in[0] = 1 → out = 1.
- **Overrun:** second strobe at cycle 2 → first result correct at cycle 6, no second out_valid, overrun = 1 until reset.
- **Reset mid-mix:** reset asserted at cycle 3 → no out_valid, out = 0, busy = 0 at cycle 4; a strobe at cycle 5 produces a correct result at cycle 11.
- **Input change after snapshot:** in toggles every cycle after cycle 0 → out equals the mix of the cycle-0 values.

Source files
------------

// File: rtl/discrete_audio_pkg.sv
// Shared types and helpers for the discrete audio stages.
// Provides the 16-bit sample type, the Q4.12 unity gain, and 36-bit to 16-bit saturation.
package discrete_audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int unsigned GAIN_UNITY_12 = 4096;

    typedef struct packed {
        sample_t value;
        logic    clip;
    } sat16_t;

    function automatic sat16_t sat16(input logic signed [35:0] x);
        sat16_t res;
        if (x > 36'sd32767) begin
            res.value = 16'sh7fff;
            res.clip  = 1'b1;
        end else if (x < -36'sd32768) begin
            res.value = 16'sh8000;
            res.clip  = 1'b1;
        end else begin
            res.value = x[15:0];
            res.clip  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/sample_saturator.sv
// Rounds a Q.12 accumulator to an integer sample (half toward +inf) and saturates to 16 bits.
module sample_saturator
    import discrete_audio_pkg::*;
(
    input  logic signed [35:0] acc,
    output sample_t            value,
    output logic               clip
);

    logic signed [35:0] rounded;
    sat16_t             sat;

    always_comb begin
        rounded = (acc + 36'sd2048) >>> 12;
        sat     = sat16(rounded);
    end

    assign value = sat.value;
    assign clip  = sat.clip;

endmodule

// File: rtl/discrete_weighted_mixer.sv
// Weighted sum of NUM_INPUTS signed samples with Q4.12 gains, using one shared
// multiply-accumulate stepped once per input after each audio strobe.
module discrete_weighted_mixer
    import discrete_audio_pkg::*;
#(
    parameter int CLOCK_RATE  = 50000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int NUM_INPUTS  = 4,
    parameter logic [NUM_INPUTS*16-1:0] GAINS_12_SHIFTED = {NUM_INPUTS{16'(GAIN_UNITY_12)}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         audio_clk_en,
    input  logic [NUM_INPUTS*16-1:0]     in,
    output logic signed [15:0]           out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         clip,
    output logic                         overrun
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    if (NUM_INPUTS < 2 || NUM_INPUTS > 8) begin : g_bad_num_inputs
        $error("discrete_weighted_mixer: NUM_INPUTS must be in 2..8");
    end
    if (CLOCK_RATE / SAMPLE_RATE < NUM_INPUTS + 3) begin : g_bad_rate
        $error("discrete_weighted_mixer: too few clocks per sample for NUM_INPUTS");
    end

    typedef enum logic [1:0] {StIdle, StAccum, StScale} mixer_state_t;

    mixer_state_t       state_q, state_d;
    sample_t            snap_q [NUM_INPUTS];
    logic signed [35:0] acc_q;
    logic [IDX_W-1:0]   idx_q;

    logic               start, accum_en, scale_en, drop;
    sample_t            cur_sample;
    logic [15:0]        cur_gain;
    logic signed [32:0] product;
    sample_t            sat_value;
    logic               sat_clip;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (audio_clk_en) state_d = StAccum;
            StAccum: if (idx_q == LAST_IDX) state_d = StScale;
            StScale: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle);
        start    = (state_q == StIdle) && audio_clk_en;
        accum_en = (state_q == StAccum);
        scale_en = (state_q == StScale);
        drop     = audio_clk_en && (state_q != StIdle);
    end

    // Operand mux for the shared multiplier; gain is unsigned, so zero-extend before signed multiply.
    always_comb begin
        cur_sample = '0;
        cur_gain   = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_sample = snap_q[i];
                cur_gain   = GAINS_12_SHIFTED[16*i +: 16];
            end
        end
        product = 33'(cur_sample) * 33'($signed({1'b0, cur_gain}));
    end

    sample_saturator u_sample_saturator (
        .acc   (acc_q),
        .value (sat_value),
        .clip  (sat_clip)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                snap_q[i] <= '0;
            end
            acc_q     <= '0;
            idx_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (start) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    snap_q[i] <= in[16*i +: 16];
                end
                acc_q <= '0;
                idx_q <= '0;
            end
            if (accum_en) begin
                acc_q <= acc_q + 36'(product);
                idx_q <= idx_q + IDX_W'(1);
            end
            if (scale_en) begin
                out       <= sat_value;
                clip      <= sat_clip;
                out_valid <= 1'b1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_discrete_weighted_mixer.sv
// Directed bench for discrete_weighted_mixer: unity, 2x and rounding-gain instances share stimulus.
module tb_discrete_weighted_mixer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        audio_clk_en;
    logic [63:0] in_bus;

    logic signed [15:0] out_u, out_s, out_r;
    logic valid_u, busy_u, clip_u, ovr_u;
    logic valid_s, busy_s, clip_s, ovr_s;
    logic valid_r, busy_r, clip_r, ovr_r;

    int errors = 0;
    int checks = 0;

    discrete_weighted_mixer u_dut (
        .clk          (clk),
        .reset        (reset),
        .audio_clk_en (audio_clk_en),
        .in           (in_bus),
        .out          (out_u),
        .out_valid    (valid_u),
        .busy         (busy_u),
        .clip         (clip_u),
        .overrun      (ovr_u)
    );

    discrete_weighted_mixer #(
        .GAINS_12_SHIFTED ({4{16'd8192}})
    ) u_dut_x2 (
        .clk          (clk),
        .reset        (reset),
        .audio_clk_en (audio_clk_en),
        .in           (in_bus),
        .out          (out_s),
        .out_valid    (valid_s),
        .busy         (busy_s),
        .clip         (clip_s),
        .overrun      (ovr_s)
    );

    discrete_weighted_mixer #(
        .GAINS_12_SHIFTED ({16'd0, 16'd0, 16'd0, 16'd2048})
    ) u_dut_rnd (
        .clk          (clk),
        .reset        (reset),
        .audio_clk_en (audio_clk_en),
        .in           (in_bus),
        .out          (out_r),
        .out_valid    (valid_r),
        .busy         (busy_r),
        .clip         (clip_r),
        .overrun      (ovr_r)
    );

    task automatic check_value(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack4(input int i0, input int i1, input int i2, input int i3);
        return {16'(i3), 16'(i2), 16'(i1), 16'(i0)};
    endfunction

    // Strobe at cycle 0, checks busy/out_valid over cycles 1..5, returns in cycle 6.
    task automatic run_mix(input logic [63:0] vec, input logic [63:0] alt, input bit toggle,
                           input int second_at);
        in_bus       = vec;
        audio_clk_en = 1'b1;
        tick();
        audio_clk_en = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check_value("busy_during_mix", busy_u, 1);
            check_value("no_early_valid", valid_u, 0);
            if (toggle) in_bus = (c % 2 == 1) ? alt : ~alt;
            audio_clk_en = (c == second_at);
            tick();
        end
        audio_clk_en = 1'b0;
        check_value("valid_at_cycle6", valid_u, 1);
        check_value("busy_done", busy_u, 0);
    endtask

    initial begin
        in_bus       = '0;
        reset        = 1'b1;
        audio_clk_en = 1'b1;
        tick();
        audio_clk_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        check_value("reset_out", out_u, 0);
        check_value("reset_valid", valid_u, 0);
        check_value("reset_busy", busy_u, 0);
        check_value("reset_clip", clip_u, 0);
        check_value("reset_overrun", ovr_u, 0);

        // Basic sum
        run_mix(pack4(1000, 2000, -500, 0), '0, 1'b0, 0);
        check_value("basic_out", out_u, 2500);
        check_value("basic_clip", clip_u, 0);
        check_value("basic_x2_out", out_s, 5000);
        check_value("basic_rnd_out", out_r, 500);
        tick();
        check_value("valid_one_cycle", valid_u, 0);
        check_value("out_holds", out_u, 2500);
        check_value("no_overrun_yet", ovr_u, 0);

        // Saturation
        run_mix(pack4(20000, 20000, 20000, 20000), '0, 1'b0, 0);
        check_value("sat_pos_x2_out", out_s, 32767);
        check_value("sat_pos_x2_clip", clip_s, 1);
        check_value("sat_pos_unity_out", out_u, 32767);
        run_mix(pack4(-32768, -32768, -32768, -32768), '0, 1'b0, 0);
        check_value("sat_neg_out", out_u, -32768);
        check_value("sat_neg_clip", clip_u, 1);

        // Rounding with gain 0.5 on input 0
        run_mix(pack4(3, 7, 7, 7), '0, 1'b0, 0);
        check_value("round_p3", out_r, 2);
        check_value("round_clip", clip_r, 0);
        run_mix(pack4(-3, 7, 7, 7), '0, 1'b0, 0);
        check_value("round_m3", out_r, -1);
        run_mix(pack4(1, 7, 7, 7), '0, 1'b0, 0);
        check_value("round_p1", out_r, 1);
        run_mix(pack4(-1, 7, 7, 7), '0, 1'b0, 0);
        check_value("round_m1", out_r, 0);
        check_value("unity_clip_cleared", clip_u, 0);

        // Input toggling after snapshot
        run_mix(pack4(100, 200, 300, 400), pack4(-7000, 9000, 12345, -3), 1'b1, 0);
        check_value("snapshot_out", out_u, 1000);

        // Overrun: second strobe at cycle 2
        run_mix(pack4(10, 20, 30, 40), '0, 1'b0, 2);
        check_value("overrun_first_out", out_u, 100);
        check_value("overrun_flag", ovr_u, 1);
        for (int c = 0; c < 8; c++) begin
            tick();
            check_value("overrun_no_second_valid", valid_u, 0);
        end
        check_value("overrun_sticky", ovr_u, 1);

        // Reset mid-mix at cycle 3
        in_bus       = pack4(1, 2, 3, 4);
        audio_clk_en = 1'b1;
        tick();
        audio_clk_en = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_value("midreset_valid", valid_u, 0);
        check_value("midreset_out", out_u, 0);
        check_value("midreset_busy", busy_u, 0);
        check_value("midreset_overrun", ovr_u, 0);
        tick();
        in_bus       = pack4(-100, 50, 25, 1000);
        audio_clk_en = 1'b1;
        tick();
        audio_clk_en = 1'b0;
        for (int c = 6; c <= 10; c++) begin
            check_value("post_reset_no_valid", valid_u, 0);
            tick();
        end
        check_value("post_reset_valid", valid_u, 1);
        check_value("post_reset_out", out_u, 975);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
